// File: rtl/darkroom_pkg.sv
// Shared constants and types for the sensor value splitter.
// Holds default sizes, the index width and the splitter state enum.
package darkroom_pkg;

    localparam int NUM_SENSORS_DEF = 8;
    localparam int SENSOR_W_DEF    = 32;
    localparam int IDX_W_DEF       = $clog2(NUM_SENSORS_DEF);

    typedef enum logic {
        IDLE,
        SEND
    } splitter_state_t;

endpackage

// File: rtl/sensor_value_splitter_if.sv
// Valid/ready word stream produced by the sensor value splitter.
// master: out_valid/out_data/out_index/out_last out, out_ready in.
interface sensor_value_splitter_if #(
    parameter int SENSOR_W = 32,
    parameter int IDX_W    = 3
);
    logic                out_valid;
    logic                out_ready;
    logic [SENSOR_W-1:0] out_data;
    logic [IDX_W-1:0]    out_index;
    logic                out_last;

    modport master (
        output out_valid, out_data, out_index, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/sensor_next_index.sv
// Combinational priority finder: lowest set mask bit above cur.
// Ports: mask, cur in; nxt (found index), none (no such bit) out.
module sensor_next_index #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] cur,
    output logic [IDX_W-1:0] nxt,
    output logic             none
);
    always_comb begin
        nxt  = '0;
        none = 1'b1;
        // Descending scan so the lowest qualifying index wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && (IDX_W'(i) > cur)) begin
                nxt  = IDX_W'(i);
                none = 1'b0;
            end
        end
    end
endmodule

// File: rtl/sensor_value_splitter.sv
// Snapshots a packed sensor bus on start and streams it word by word.
// Ports: clk, reset, data, start in; busy, done, overrun out; out_if
// carries the valid/ready word stream. Macro SENSOR_SKIP_INVALID_EN
// emits only words whose MSB valid flag is set.
module sensor_value_splitter
    import darkroom_pkg::*;
#(
    parameter int NUM_SENSORS = NUM_SENSORS_DEF,
    parameter int SENSOR_W    = SENSOR_W_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_SENSORS*SENSOR_W-1:0] data,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            overrun,
    sensor_value_splitter_if.master         out_if
);
    localparam int IDX_W = $clog2(NUM_SENSORS);

    splitter_state_t               state_q, state_d;
    logic [NUM_SENSORS*SENSOR_W-1:0] snap_q, snap_d;
    logic                          valid_q, valid_d;
    logic [SENSOR_W-1:0]           word_q, word_d;
    logic [IDX_W-1:0]              index_q, index_d;
    logic                          last_q, last_d;
    logic                          done_q, done_d;
    logic                          overrun_q, overrun_d;

    logic [IDX_W-1:0] first_idx, nxt_idx;
    logic             first_none, first_last, nxt_last, nxt_none;
    logic             hs;

`ifdef SENSOR_SKIP_INVALID_EN
    logic [NUM_SENSORS-1:0] mask_q, mask_d, mask_in;
    logic [IDX_W-1:0]       f0_idx, fn_idx;
    logic                   f0_none, fn_none;

    always_comb begin
        mask_in = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            mask_in[i] = data[i*SENSOR_W + SENSOR_W - 1];
        end
    end

    sensor_next_index #(.N(NUM_SENSORS), .IDX_W(IDX_W)) u_first (
        .mask (mask_in),
        .cur  ('0),
        .nxt  (f0_idx),
        .none (f0_none)
    );

    sensor_next_index #(.N(NUM_SENSORS), .IDX_W(IDX_W)) u_next (
        .mask (mask_q),
        .cur  (index_q),
        .nxt  (fn_idx),
        .none (fn_none)
    );

    // The finder only looks above cur, so bit 0 is handled here.
    assign first_idx  = mask_in[0] ? '0 : f0_idx;
    assign first_none = !mask_in[0] && f0_none;
    assign first_last = ((mask_in >> first_idx) >> 1) == '0;
    assign nxt_idx    = fn_idx;
    assign nxt_none   = fn_none;
    assign nxt_last   = ((mask_q >> fn_idx) >> 1) == '0;
`else
    assign first_idx  = '0;
    assign first_none = 1'b0;
    assign first_last = 1'b0;
    assign nxt_idx    = index_q + IDX_W'(1);
    assign nxt_none   = 1'b0;
    assign nxt_last   = nxt_idx == IDX_W'(NUM_SENSORS - 1);
`endif

    assign hs = valid_q && out_if.out_ready;

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        valid_d   = valid_q;
        word_d    = word_q;
        index_d   = index_q;
        last_d    = last_q;
        done_d    = 1'b0;
        overrun_d = 1'b0;
`ifdef SENSOR_SKIP_INVALID_EN
        mask_d    = mask_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = data;
                    state_d = SEND;
`ifdef SENSOR_SKIP_INVALID_EN
                    mask_d  = mask_in;
`endif
                    if (first_none) begin
                        // Nothing flagged: one busy cycle, no words.
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        index_d = first_idx;
                        word_d  = data[int'(first_idx)*SENSOR_W +: SENSOR_W];
                        last_d  = first_last;
                    end
                end
            end
            SEND: begin
                overrun_d = start;
                if (!valid_q) begin
                    state_d = IDLE;
                end else if (hs) begin
                    if (last_q || nxt_none) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        index_d = nxt_idx;
                        word_d  = snap_q[int'(nxt_idx)*SENSOR_W +: SENSOR_W];
                        last_d  = nxt_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            valid_q   <= 1'b0;
            word_q    <= '0;
            index_q   <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SENSOR_SKIP_INVALID_EN
            mask_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            valid_q   <= valid_d;
            word_q    <= word_d;
            index_q   <= index_d;
            last_q    <= last_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
`ifdef SENSOR_SKIP_INVALID_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign busy             = state_q == SEND;
    assign done             = done_q;
    assign overrun          = overrun_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = word_q;
    assign out_if.out_index = index_q;
    assign out_if.out_last  = last_q;
endmodule

// File: tb/tb_sensor_value_splitter.sv
// Scoreboard bench for sensor_value_splitter.
// Directed streams, backpressure, overrun, back-to-back and reset.
module tb_sensor_value_splitter;
    localparam int N = 8;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] d;
        logic [2:0]   i;
        logic         l;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [N*W-1:0] data;
    logic           busy, done, overrun;

    sensor_value_splitter_if #(.SENSOR_W(W), .IDX_W(3)) ifc ();

    sensor_value_splitter #(.NUM_SENSORS(N), .SENSOR_W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .data    (data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .overrun (overrun),
        .out_if  (ifc.master)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   hs_cyc = -10;
    logic stall_q = 1'b0;
    exp_t prev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", 64'(ifc.out_valid), 64'd1);
                chk("hold_data", 64'(ifc.out_data), 64'(prev.d));
                chk("hold_index", 64'(ifc.out_index), 64'(prev.i));
                chk("hold_last", 64'(ifc.out_last), 64'(prev.l));
            end
            stall_q = ifc.out_valid && !ifc.out_ready;
            prev.d = ifc.out_data;
            prev.i = ifc.out_index;
            prev.l = ifc.out_last;
            if (ifc.out_valid && ifc.out_ready) begin
                hs_cyc = cyc;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got index %0d, none expected",
                             ifc.out_index);
                end else begin
                    e = q.pop_front();
                    chk("word_data", 64'(ifc.out_data), 64'(e.d));
                    chk("word_index", 64'(ifc.out_index), 64'(e.i));
                    chk("word_last", 64'(ifc.out_last), 64'(e.l));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] pat(input logic [W-1:0] base);
        logic [N*W-1:0] p;
        for (int i = 0; i < N; i++) p[i*W +: W] = base + W'(i);
        return p;
    endfunction

    task automatic push_all(input logic [N*W-1:0] d);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.d = d[i*W +: W];
            e.i = 3'(i);
            e.l = (i == N - 1);
            q.push_back(e);
        end
    endtask

    task automatic push_one(input logic [W-1:0] d, input int i, input logic l);
        exp_t e;
        e.d = d;
        e.i = 3'(i);
        e.l = l;
        q.push_back(e);
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: no done within %0d cycles", max);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_valid"}, 64'(ifc.out_valid), 64'd0);
        chk({tag, "_last"}, 64'(ifc.out_last), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_overrun"}, 64'(overrun), 64'd0);
        chk({tag, "_data"}, 64'(ifc.out_data), 64'd0);
        chk({tag, "_index"}, 64'(ifc.out_index), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [N*W-1:0] pa, pb, pc, pf;
        pa = pat(32'hA000_0000);
        pb = pat(32'hB000_0000);
        pc = pat(32'hC000_0000);

        reset = 1'b1;
        start = 1'b0;
        data  = '0;
        ifc.out_ready = 1'b0;
        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b0;
        tick();

        // Basic stream with ready held high.
        data = pa;
        ifc.out_ready = 1'b1;
        start = 1'b1;
        push_all(pa);
        tick();
        start = 1'b0;
        chk("first_valid", 64'(ifc.out_valid), 64'd1);
        chk("first_index", 64'(ifc.out_index), 64'd0);
        chk("first_data", 64'(ifc.out_data), 64'hA000_0000);
        chk("first_busy", 64'(busy), 64'd1);
        wait_done(50, n);
        chk("done_latency", 64'(n), 64'd8);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_valid", 64'(ifc.out_valid), 64'd0);
        chk("done_after_hs", 64'(cyc), 64'(hs_cyc + 1));
        tick();
        chk("done_pulse", 64'(done), 64'd0);

        // Backpressure with ready toggling.
        start = 1'b1;
        push_all(pa);
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            ifc.out_ready = ~ifc.out_ready;
            tick();
            n++;
        end
        chk("bp_done", 64'(done), 64'd1);
        chk("bp_done_after_hs", 64'(cyc), 64'(hs_cyc + 1));
        ifc.out_ready = 1'b1;
        tick();

        // Snapshot isolation and overrun.
        data = pa;
        start = 1'b1;
        push_all(pa);
        tick();
        start = 1'b0;
        data = '1;
        for (int e = 1; e <= 8; e++) begin
            start = (e == 3);
            tick();
            chk("overrun", 64'(overrun), 64'(e == 3));
        end
        start = 1'b0;
        chk("ovr_done", 64'(done), 64'd1);
        tick();

        // Back-to-back: restart in the done cycle.
        data = pb;
        start = 1'b1;
        push_all(pb);
        tick();
        start = 1'b0;
        wait_done(50, n);
        data = pc;
        start = 1'b1;
        push_all(pc);
        tick();
        start = 1'b0;
        chk("b2b_valid", 64'(ifc.out_valid), 64'd1);
        chk("b2b_index", 64'(ifc.out_index), 64'd0);
        chk("b2b_data", 64'(ifc.out_data), 64'hC000_0000);
        chk("b2b_overrun", 64'(overrun), 64'd0);
        wait_done(50, n);
        chk("b2b_latency", 64'(n), 64'd8);
        tick();

        // Reset mid-stream.
        data = pa;
        start = 1'b1;
        push_all(pa);
        tick();
        start = 1'b0;
        n = 0;
        while (ifc.out_index != 3'd4 && n < 20) begin
            tick();
            n++;
        end
        chk("rst_at_index", 64'(ifc.out_index), 64'd4);
        reset = 1'b1;
        ifc.out_ready = 1'b0;
        tick();
        chk_zero("midrst");
        q.delete();
        reset = 1'b0;
        ifc.out_ready = 1'b1;
        tick();
        chk("post_rst_done", 64'(done), 64'd0);
        start = 1'b1;
        push_all(pa);
        tick();
        start = 1'b0;
        chk("post_rst_index", 64'(ifc.out_index), 64'd0);
        chk("post_rst_data", 64'(ifc.out_data), 64'hA000_0000);
        wait_done(50, n);
        chk("post_rst_latency", 64'(n), 64'd8);
        tick();

`ifdef SENSOR_SKIP_INVALID_EN
        // Only flagged words 1, 5, 6.
        for (int i = 0; i < N; i++) begin
            pf[i*W +: W] = 32'h100 + 32'(i);
            if (i == 1 || i == 5 || i == 6) pf[i*W + W - 1] = 1'b1;
        end
        data = pf;
        push_one(32'h8000_0101, 1, 1'b0);
        push_one(32'h8000_0105, 5, 1'b0);
        push_one(32'h8000_0106, 6, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("skip_first_index", 64'(ifc.out_index), 64'd1);
        wait_done(50, n);
        chk("skip_latency", 64'(n), 64'd3);
        tick();

        // No flagged words.
        data = pat(32'h10);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_done", 64'(done), 64'd1);
        chk("empty_valid", 64'(ifc.out_valid), 64'd0);
        chk("empty_busy", 64'(busy), 64'd1);
        tick();
        chk("empty_busy2", 64'(busy), 64'd0);
        chk("empty_done2", 64'(done), 64'd0);
        chk("empty_valid2", 64'(ifc.out_valid), 64'd0);
        tick();
`else
        pf = '0;
        data = pf;
`endif

        repeat (2) tick();
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
